dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 64; number of 32-bit data words stored.
REQ-002 SHALL have parameter WAIT_CYCLES, default 1; wait-state cycles between accept and response (0 to 15).
REQ-003 SHALL have parameter MAILBOX_ADR, default 32'd44; byte address of the pass/fail mailbox.
REQ-004 SHALL have parameter PASS_VALUE, default 32'hFFFF_FFFD (-3); mailbox value that signals pass.
REQ-005 SHALL have port clk, input, 1 bit; single clock, rising-edge.
REQ-006 SHALL have port reset, input, 1 bit; synchronous, active-high.
REQ-007 SHALL have port req_valid, input, 1 bit; processor presents a request.
REQ-008 SHALL have port MemWrite, input, 1 bit; 1 = store, 0 = load.
REQ-009 SHALL have port DataAdr, input, 32 bits; byte address.
REQ-010 SHALL have port WriteData, input, 32 bits; store data.
REQ-011 SHALL have port ByteEn, input, 4 bits; store byte lanes, bit i = WriteData[8i+7:8i].
REQ-012 SHALL have port req_ready, output, 1 bit; responder can accept a request.
REQ-013 SHALL have port rsp_valid, output, 1 bit; one-cycle completion strobe.
REQ-014 SHALL have port ReadData, output, 32 bits; load result, valid while rsp_valid=1.
REQ-015 SHALL have ports done, pass, fail, output, 1 bit each; sticky test-status flags.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-017 SHALL assert req_ready only in IDLE; a request is accepted on a rising edge where req_valid=1 and req_ready=1.
REQ-018 SHALL on accept capture MemWrite, DataAdr, WriteData and ByteEn, load the wait counter with WAIT_CYCLES, and go to WAIT, or go directly to RESP when WAIT_CYCLES=0.
REQ-019 SHALL in WAIT decrement the counter each cycle and go to RESP on the cycle after the counter reaches 1.
REQ-020 SHALL in RESP assert rsp_valid for exactly one cycle, then return to IDLE; accept-to-rsp_valid latency = WAIT_CYCLES+1 cycles.
REQ-021 SHALL index memory with word = DataAdr[31:2]; an index >= DEPTH_WORDS is out of range.
REQ-022 SHALL commit a store in the RESP cycle, writing only enabled lanes; ByteEn=0 writes nothing.
REQ-023 SHALL for a load drive ReadData with mem[word] in RESP; for a store, or an out-of-range load, ReadData = 0.
REQ-024 SHALL silently drop out-of-range stores, with no flag change.
REQ-025 SHALL treat a request with DataAdr[1:0] != 0 as misaligned: no memory access, ReadData=0, set fail and done in RESP.
REQ-026 SHALL on a store to MAILBOX_ADR with ByteEn=4'hF and WriteData=PASS_VALUE set pass and done in RESP; any other store to MAILBOX_ADR sets fail and done.
REQ-027 SHALL keep done, pass and fail set until reset; if pass is already set, a later fail event SHALL still set fail, so both may read 1.
REQ-028 SHALL continue servicing requests after done=1.
REQ-029 SHALL keep the mailbox word as a normal memory location, so stores to it are also committed.

Reset
REQ-030 SHALL on reset=1 at a rising edge force IDLE, rsp_valid=0, ReadData=0, done=pass=fail=0, and wait counter=0.
REQ-031 SHALL on reset during WAIT or RESP abort the request with no memory commit and no flag update.
REQ-032 SHALL leave memory contents unchanged by reset.
REQ-033 SHALL drive req_ready=1 in the first cycle after reset deasserts.

Verification
REQ-034 Store 0x12345678 to address 8 (ByteEn=F), then load address 8, with WAIT_CYCLES=1 -> each rsp_valid 2 cycles after accept; load ReadData=0x12345678.
REQ-035 Store 0xAABBCCDD to address 8 with ByteEn=4'b0101 over the prior value -> later load returns 0x12BB56DD.
REQ-036 Store 0xFFFFFFFD to address 44 (ByteEn=F) -> in the RESP cycle pass=1 and done=1, fail=0; flags persist through 10 further idle cycles.
REQ-037 Store 7 to address 44, then store 25 to address 96 -> fail=1 and done=1 after the first store; address 96 then holds 25.
REQ-038 Load address 6, then load address 4*DEPTH_WORDS -> first load gives fail=1 and ReadData=0; second load gives ReadData=0.
REQ-039 Assert reset in the WAIT cycle of a store to address 0 with WAIT_CYCLES=3 -> no rsp_valid, mem[0] unchanged, req_ready=1 the cycle after reset drops.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder for a processor test harness: byte-lane memory with fixed
// wait states, a one-cycle completion strobe and sticky pass/fail mailbox flags.
module dmem_responder #(
   parameter int          DEPTH_WORDS = 64,
   parameter int          WAIT_CYCLES = 1,
   parameter logic [31:0] MAILBOX_ADR = 32'd44,
   parameter logic [31:0] PASS_VALUE  = 32'hFFFF_FFFD
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        MemWrite,
   input  logic [31:0] DataAdr,
   input  logic [31:0] WriteData,
   input  logic [3:0]  ByteEn,
   output logic        req_ready,
   output logic        rsp_valid,
   output logic [31:0] ReadData,
   output logic        done,
   output logic        pass,
   output logic        fail
);

   localparam int IdxW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} stateT;

   stateT       state;
   logic [3:0]  waitCnt;

   logic        capWrite;
   logic [31:0] capAdr;
   logic [31:0] capData;
   logic [3:0]  capBe;

   logic [31:0] mem [DEPTH_WORDS];

   logic        accept;
   logic        enterResp;
   logic        selWrite;
   logic [31:0] selAdr;
   logic [31:0] selData;
   logic [3:0]  selBe;
   logic [29:0] selWord;
   logic [IdxW-1:0] selIdx;
   logic        selAligned;
   logic        selInRange;
   logic        mailboxHit;
   logic        passEvent;
   logic        failEvent;
   logic [31:0] loadValue;

   assign accept    = (state == IDLE) && req_valid && req_ready;
   assign enterResp = (accept && (WAIT_CYCLES == 0)) || ((state == WAIT) && (waitCnt == 4'd1));

   // With zero wait states the response is formed on the accept edge itself, so
   // the live request is used before it has been captured.
   // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      selWrite = capWrite;
      selAdr   = capAdr;
      selData  = capData;
      selBe    = capBe;
      if (state == IDLE) begin
         selWrite = MemWrite;
         selAdr   = DataAdr;
         selData  = WriteData;
         selBe    = ByteEn;
      end
   end

   assign selWord    = selAdr[31:2];
   assign selIdx     = selWord[IdxW-1:0];
   assign selAligned = (selAdr[1:0] == 2'b00);
   assign selInRange = ({2'b00, selWord} < 32'(DEPTH_WORDS));

   assign mailboxHit = selWrite && selAligned && (selAdr == MAILBOX_ADR);
   assign passEvent  = mailboxHit && (selBe == 4'hF) && (selData == PASS_VALUE);
   assign failEvent  = !selAligned || (mailboxHit && !passEvent);
   assign loadValue  = (!selWrite && selAligned && selInRange) ? mem[selIdx] : 32'd0;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         waitCnt   <= 4'd0;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         ReadData  <= 32'd0;
         done      <= 1'b0;
         pass      <= 1'b0;
         fail      <= 1'b0;
      end else begin
         if (enterResp) begin
            rsp_valid <= 1'b1;
            ReadData  <= loadValue;
            if (passEvent) begin
               pass <= 1'b1;
               done <= 1'b1;
            end
            if (failEvent) begin
               fail <= 1'b1;
               done <= 1'b1;
            end
         end

         case (state)
            IDLE: begin
               if (accept) begin
                  req_ready <= 1'b0;
                  waitCnt   <= 4'(WAIT_CYCLES);
                  state     <= (WAIT_CYCLES == 0) ? RESP : WAIT;
               end
            end
            WAIT: begin
               waitCnt <= waitCnt - 4'd1;
               if (waitCnt == 4'd1) begin
                  state <= RESP;
               end
            end
            RESP: begin
               rsp_valid <= 1'b0;
               ReadData  <= 32'd0;
               req_ready <= 1'b1;
               state     <= IDLE;
            end
            default: begin
               state     <= IDLE;
               req_ready <= 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         capWrite <= MemWrite;
         capAdr   <= DataAdr;
         capData  <= WriteData;
         capBe    <= ByteEn;
      end
   end

   // Stores commit on the edge that closes the RESP cycle, so a reset during RESP
   // aborts them cleanly.
   // NOTE: the memory array has no reset; its contents survive reset by design.
   always_ff @(posedge clk) begin
      if (!reset && (state == RESP) && selWrite && selAligned && selInRange) begin
         for (int b = 0; b < 4; b++) begin
            if (selBe[b]) begin
               mem[selIdx][8*b +: 8] <= selData[8*b +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus randomized traffic
// compared against a byte-array reference model.
module tb_dmem_responder;

   localparam int          DEPTH = 64;
   localparam int          WA    = 1;
   localparam int          WB    = 3;
   localparam logic [31:0] MBOX  = 32'd44;
   localparam logic [31:0] PASSV = 32'hFFFF_FFFD;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        aReset, aReqValid, aMemWrite, aReady, aRspValid, aDone, aPass, aFail;
   logic [31:0] aAdr, aWData, aRData;
   logic [3:0]  aBe;
   logic        bReset, bReqValid, bMemWrite, bReady, bRspValid, bDone, bPass, bFail;
   logic [31:0] bAdr, bWData, bRData;
   logic [3:0]  bBe;

   dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WA), .MAILBOX_ADR(MBOX), .PASS_VALUE(PASSV)) dutA (
      .clk(clk), .reset(aReset), .req_valid(aReqValid), .MemWrite(aMemWrite), .DataAdr(aAdr),
      .WriteData(aWData), .ByteEn(aBe), .req_ready(aReady), .rsp_valid(aRspValid),
      .ReadData(aRData), .done(aDone), .pass(aPass), .fail(aFail));

   dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WB), .MAILBOX_ADR(MBOX), .PASS_VALUE(PASSV)) dutB (
      .clk(clk), .reset(bReset), .req_valid(bReqValid), .MemWrite(bMemWrite), .DataAdr(bAdr),
      .WriteData(bWData), .ByteEn(bBe), .req_ready(bReady), .rsp_valid(bRspValid),
      .ReadData(bRData), .done(bDone), .pass(bPass), .fail(bFail));

   int checks   = 0;
   int failures = 0;

   // Reference model for dutA: memory as bytes plus the three sticky flags.
   logic [7:0] mBytes [4*DEPTH];
   logic       mDone, mPass, mFail;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Issues one request to either instance and reports latency, response data and
   // the flags seen in the response cycle.
   task automatic doReq(input bit useB, input logic wr, input logic [31:0] adr, input logic [31:0] data,
                        input logic [3:0] be, output int lat, output logic [31:0] rd, output logic [2:0] flg);
      int n;
      n = 0;
      while (!(useB ? bReady : aReady) && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("req_ready before request", 32'(useB ? bReady : aReady), 32'd1);
      if (useB) begin
         bReqValid = 1'b1; bMemWrite = wr; bAdr = adr; bWData = data; bBe = be;
      end else begin
         aReqValid = 1'b1; aMemWrite = wr; aAdr = adr; aWData = data; aBe = be;
      end
      @(posedge clk);
      @(negedge clk);
      if (useB) bReqValid = 1'b0;
      else      aReqValid = 1'b0;
      lat = 1;
      while (!(useB ? bRspValid : aRspValid) && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      rd  = useB ? bRData : aRData;
      flg = useB ? {bDone, bPass, bFail} : {aDone, aPass, aFail};
      @(negedge clk);
      check("rsp_valid single cycle", 32'(useB ? bRspValid : aRspValid), 32'd0);
   endtask

   task automatic reqA(input string tag, input logic wr, input logic [31:0] adr, input logic [31:0] data,
                       input logic [3:0] be);
      int          lat, wi;
      logic [31:0] rd, expRd;
      logic [2:0]  flg;
      bit          inr, mis;
      wi    = int'(adr[31:2]);
      inr   = (wi < DEPTH);
      mis   = (adr[1:0] != 2'b00);
      expRd = 32'd0;
      if (!wr && !mis && inr)
         expRd = {mBytes[4*wi+3], mBytes[4*wi+2], mBytes[4*wi+1], mBytes[4*wi]};
      if (mis) begin
         mFail = 1'b1; mDone = 1'b1;
      end else if (wr && adr == MBOX) begin
         if (be == 4'hF && data == PASSV) mPass = 1'b1;
         else                             mFail = 1'b1;
         mDone = 1'b1;
      end
      if (wr && !mis && inr)
         for (int b = 0; b < 4; b++)
            if (be[b]) mBytes[4*wi+b] = data[8*b +: 8];
      doReq(1'b0, wr, adr, data, be, lat, rd, flg);
      check({tag, " latency"}, 32'(lat), 32'(WA + 1));
      check({tag, " ReadData"}, rd, expRd);
      check({tag, " done/pass/fail"}, 32'(flg), 32'({mDone, mPass, mFail}));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          lat, wi, sel;
      logic [31:0] rd, adr;
      logic [2:0]  flg;
      bit          sawRsp;

      aReset = 1'b1; aReqValid = 1'b0; aMemWrite = 1'b0; aAdr = '0; aWData = '0; aBe = '0;
      bReset = 1'b1; bReqValid = 1'b0; bMemWrite = 1'b0; bAdr = '0; bWData = '0; bBe = '0;
      mDone = 1'b0; mPass = 1'b0; mFail = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset rsp_valid", 32'(aRspValid), 32'd0);
      check("reset ReadData", aRData, 32'd0);
      check("reset flags", 32'({aDone, aPass, aFail}), 32'd0);
      aReset = 1'b0;
      bReset = 1'b0;
      @(negedge clk);
      check("req_ready after reset", 32'(aReady), 32'd1);

      for (int w = 0; w < DEPTH; w++)
         if (w != int'(MBOX[31:2])) reqA("init store", 1'b1, 32'(w * 4), $urandom, 4'hF);

      reqA("mailbox pass", 1'b1, MBOX, PASSV, 4'hF);
      repeat (10) @(negedge clk);
      check("flags persist idle", 32'({aDone, aPass, aFail}), 32'b110);

      reqA("store 8", 1'b1, 32'd8, 32'h1234_5678, 4'hF);
      reqA("load 8", 1'b0, 32'd8, 32'd0, 4'h0);
      reqA("partial store 8", 1'b1, 32'd8, 32'hAABB_CCDD, 4'b0101);
      reqA("load 8 merged", 1'b0, 32'd8, 32'd0, 4'h0);
      reqA("no-lane store", 1'b1, 32'd8, 32'hDEAD_BEEF, 4'h0);
      reqA("load 8 unchanged", 1'b0, 32'd8, 32'd0, 4'h0);

      reqA("mailbox bad", 1'b1, MBOX, 32'd7, 4'hF);
      reqA("store 96", 1'b1, 32'd96, 32'd25, 4'hF);
      reqA("load 96", 1'b0, 32'd96, 32'd0, 4'h0);
      reqA("load mailbox word", 1'b0, MBOX, 32'd0, 4'h0);
      reqA("misaligned load", 1'b0, 32'd6, 32'd0, 4'h0);
      reqA("out of range load", 1'b0, 32'(4 * DEPTH), 32'd0, 4'h0);
      reqA("out of range store", 1'b1, 32'hFFFF_FFFC, 32'h5555_AAAA, 4'hF);

      for (int i = 0; i < 200; i++) begin
         sel = int'($urandom_range(0, 9));
         wi  = int'($urandom_range(0, DEPTH - 1));
         case (sel)
            0:       adr = MBOX;
            1:       adr = (32'(wi) << 2) | 32'($urandom_range(1, 3));
            2:       adr = 32'($urandom_range(DEPTH, 4000)) << 2;
            default: adr = 32'(wi) << 2;
         endcase
         reqA("random", 1'($urandom_range(0, 1)), adr, $urandom, 4'($urandom_range(0, 15)));
      end

      @(negedge clk);
      aReset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      aReset = 1'b0;
      mDone = 1'b0; mPass = 1'b0; mFail = 1'b0;
      check("flags cleared by reset", 32'({aDone, aPass, aFail}), 32'd0);
      reqA("load 8 after reset", 1'b0, 32'd8, 32'd0, 4'h0);
      reqA("load 96 after reset", 1'b0, 32'd96, 32'd0, 4'h0);

      doReq(1'b1, 1'b1, 32'd0, 32'hCAFE_0001, 4'hF, lat, rd, flg);
      check("B store latency", 32'(lat), 32'(WB + 1));
      doReq(1'b1, 1'b0, 32'd0, 32'd0, 4'h0, lat, rd, flg);
      check("B load latency", 32'(lat), 32'(WB + 1));
      check("B load 0", rd, 32'hCAFE_0001);

      bReqValid = 1'b1; bMemWrite = 1'b1; bAdr = 32'd0; bWData = 32'h0BAD_0BAD; bBe = 4'hF;
      @(posedge clk);
      @(negedge clk);
      bReqValid = 1'b0;
      check("B busy in wait", 32'(bReady), 32'd0);
      bReset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bReset = 1'b0;
      check("B rsp_valid after abort", 32'(bRspValid), 32'd0);
      @(negedge clk);
      check("B req_ready after reset", 32'(bReady), 32'd1);
      sawRsp = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (bRspValid) sawRsp = 1'b1;
      end
      check("B no response after abort", 32'(sawRsp), 32'd0);
      doReq(1'b1, 1'b0, 32'd0, 32'd0, 4'h0, lat, rd, flg);
      check("B mem0 kept after abort", rd, 32'hCAFE_0001);
      check("B flags clear", 32'(flg), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
